mcycle_flag_unit: RTL
=====================

// Module: mcycle_flag_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide execution unit for the ARMv3 datapath.
//  Produces results and the 4-bit NZCV flag vector consumed by the condition-check logic.
//  Uses a Start/Busy handshake so the pipeline stalls while the operation runs.
//  Sits beside the ALU. Its flags are muxed onto ALUFlags when FlagW is set for a MUL/DIV.
// PARAMETERS
//  WIDTH   32   operand and result width, in bits (>=4)
// PORTS
//  CLK        in   1      clock, rising edge
//  RESETn     in   1      asynchronous reset, active-low
//  Start      in   1      request; sampled only in IDLE
//  MCOp       in   2      [0]: 0=MUL, 1=DIV; [1]: 1=signed (needs MCYCLE_SIGNED_EN)
//  Operand1   in   WIDTH  multiplicand / dividend
//  Operand2   in   WIDTH  multiplier / divisor
//  Result1    out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
//  Result2    out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
//  MCFlags    out  4      {N,Z,C,V}, same bit order as ALUFlags
//  Busy       out  1      stall request to the pipeline
//  Done       out  1      one-cycle pulse; results and flags valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Asynchronous reset mid-operation aborts the op and clears partial state.
//  FSM: IDLE -(Start)-> COMPUTE -(WIDTH iterations)-> DONE -> IDLE (unconditional).
//  Busy = (IDLE & Start) | COMPUTE. Busy is combinational in the Start cycle so the pipeline stalls at once.
//  Latency: Start seen at edge t. COMPUTE occupies t+1..t+WIDTH. DONE (Done=1, Busy=0) occupies t+WIDTH+1.
//  Operands and MCOp are captured at the Start edge. Later input changes are ignored.
//  Start while COMPUTE or DONE is ignored; no queueing.
//  Start in the cycle after DONE is accepted normally (back-to-back operation).
//  MUL: shift-add, one partial product per cycle; 2*WIDTH-bit accumulator.
//  DIV: restoring, one quotient bit per cycle; WIDTH+1-bit partial remainder.
//  Result1/Result2/MCFlags update only on entry to DONE, then hold until the next DONE or reset.
//  Flags: N = Result1[WIDTH-1]; Z = (Result1 == 0); C = 0 always.
//  V for MUL: high half is not the sign/zero-extension of the low half.
//  V for DIV: divide-by-zero or signed overflow.
//  Divide by zero (Operand2 == 0): Result1 = all ones, Result2 = Operand1, V = 1. Full latency is still taken.
//  Signed overflow (MIN / -1): Result1 = MIN, Result2 = 0, V = 1.
//  Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
// CONFIGURATION
//  MCYCLE_SIGNED_EN defined:
//   - MCOp[1] selects signed operation.
//   - Operands are magnitude-converted on entry; results are sign-fixed on entry to DONE. Latency is unchanged.
//  MCYCLE_SIGNED_EN undefined:
//   - MCOp[1] is ignored and every operation is unsigned.
//   - The signed-overflow case does not exist.
//   - No negate logic is synthesised.
// STRUCTURE
//  mcycle_pkg holds:
//   - state enum {IDLE, COMPUTE, DONE};
//   - MCOp bit indices (OP_DIV=0, OP_SIGNED=1);
//   - flag indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0).
//  Sub-module mcycle_sign_adj: combinational conditional two's-complement negate.
//   - Instantiated for operand entry and result fix-up.
//   - Present only under MCYCLE_SIGNED_EN.
//  Iteration counter: $clog2(WIDTH)+1 bits; terminal count WIDTH-1.
// TESTING (WIDTH=32)
//  1. MUL 7 x 6, unsigned.
//     -> Busy high from the Start cycle; Done at Start+33.
//     -> R1=42, R2=0, NZCV=0000.
//  2. DIV 100 / 7, unsigned -> R1=14, R2=2, NZCV=0000.
//  3. DIV 5 / 0 -> R1=0xFFFFFFFF, R2=5, NZCV=1001, latency 33.
//  4. Signed (MCYCLE_SIGNED_EN):
//     -> MUL -7 x 3: R1=0xFFFFFFEB, R2=0xFFFFFFFF, NZCV=1000.
//     -> DIV -7 / 2: R1=-3, R2=-1.
//     -> DIV 0x80000000 / -1: R1=0x80000000, R2=0, V=1.
//  5. Start re-pulsed and operands changed mid-COMPUTE.
//     -> Result reflects the captured operands; exactly one Done pulse.
//  6. RESETn low at COMPUTE cycle 10 -> outputs 0, IDLE.
//     -> Next Start then completes normally with correct results.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared types and bit indices for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  localparam int OP_DIV    = 0;
  localparam int OP_SIGNED = 1;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/mcycle_sign_adj.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mcycle_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mcycle_flag_unit.sv
// Iterative shift-add multiplier / restoring divider with NZCV flags and Start/Busy/Done handshake.
// Signed operation is built only when MCYCLE_SIGNED_EN is defined.
module mcycle_flag_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       MCFlags,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_div, r_sgn, r_neg_q, r_neg_r, r_dvz, r_ovf;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_res1, r_res2;
  logic [3:0]           r_flags;

  logic                 w_start, w_last, w_sgn, w_neg1, w_neg2;
  logic [WIDTH-1:0]     w_mag1, w_mag2;
  logic [WIDTH:0]       w_msum, w_shift, w_trial;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_acc_nxt, w_prod;
  logic [WIDTH-1:0]     w_q_nxt, w_rem_nxt, w_quo, w_rmd;
  logic [WIDTH-1:0]     w_r1, w_r2;
  logic                 w_v;
  logic [3:0]           w_flags;

  assign w_start = (r_state == IDLE) & Start;
  assign w_last  = (r_state == COMPUTE) & (r_cnt == LAST);
  assign Busy    = w_start | (r_state == COMPUTE);
  assign Done    = (r_state == DONE);
  assign Result1 = r_res1;
  assign Result2 = r_res2;
  assign MCFlags = r_flags;

`ifdef MCYCLE_SIGNED_EN
  assign w_sgn  = MCOp[OP_SIGNED];
  assign w_neg1 = w_sgn & Operand1[WIDTH-1];
  assign w_neg2 = w_sgn & Operand2[WIDTH-1];

  mcycle_sign_adj #(.W(WIDTH))   u_adj_a (.i_val(Operand1),  .i_neg(w_neg1),  .o_val(w_mag1));
  mcycle_sign_adj #(.W(WIDTH))   u_adj_b (.i_val(Operand2),  .i_neg(w_neg2),  .o_val(w_mag2));
  mcycle_sign_adj #(.W(2*WIDTH)) u_adj_p (.i_val(w_mul_nxt), .i_neg(r_neg_q), .o_val(w_prod));
  mcycle_sign_adj #(.W(WIDTH))   u_adj_q (.i_val(w_q_nxt),   .i_neg(r_neg_q), .o_val(w_quo));
  mcycle_sign_adj #(.W(WIDTH))   u_adj_r (.i_val(w_rem_nxt), .i_neg(r_neg_r), .o_val(w_rmd));
`else
  logic w_unused_sgn;
  assign w_sgn        = 1'b0;
  assign w_neg1       = 1'b0;
  assign w_neg2       = 1'b0;
  assign w_mag1       = Operand1;
  assign w_mag2       = Operand2;
  assign w_prod       = w_mul_nxt;
  assign w_quo        = w_q_nxt;
  assign w_rmd        = w_rem_nxt;
  assign w_unused_sgn = ^{MCOp[OP_SIGNED], r_neg_q, r_neg_r};
`endif

  // Multiply: add multiplicand into the high half when the current multiplier bit is set, then shift right.
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: low half of r_acc shifts dividend bits out and quotient bits in.
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_mcand};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_nxt   = {r_acc[WIDTH-2:0], w_ge};

  assign w_acc_nxt = r_div ? {r_acc[2*WIDTH-1:WIDTH], w_q_nxt} : w_mul_nxt;

  // Results come from the final iteration's next-state values so DONE needs no extra cycle.
  assign w_r1 = r_div ? (r_dvz ? '1 : w_quo) : w_prod[WIDTH-1:0];
  assign w_r2 = r_div ? w_rmd : w_prod[2*WIDTH-1:WIDTH];
  assign w_v  = r_div ? (r_dvz | r_ovf)
                      : (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{r_sgn & w_prod[WIDTH-1]}});

  always_comb begin
    w_flags        = '0;
    w_flags[FLG_N] = w_r1[WIDTH-1];
    w_flags[FLG_Z] = (w_r1 == '0);
    w_flags[FLG_C] = 1'b0;
    w_flags[FLG_V] = w_v;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = COMPUTE;
      COMPUTE: if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_div   <= MCOp[OP_DIV];
      r_sgn   <= w_sgn;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      r_dvz   <= (Operand2 == '0);
      r_ovf   <= w_sgn & MCOp[OP_DIV] & (Operand1 == MIN) & (Operand2 == '1);
      r_mcand <= w_mag2;
      r_acc   <= {{WIDTH{1'b0}}, w_mag1};
      r_rem   <= '0;
    end else if (r_state == COMPUTE) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
      if (r_div) r_rem <= w_rem_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_res1  <= '0;
      r_res2  <= '0;
      r_flags <= '0;
    end else if (w_last) begin
      r_res1  <= w_r1;
      r_res2  <= w_r2;
      r_flags <= w_flags;
    end
  end

endmodule
